// File: rtl/deser_fifo_pkg.sv
// Shared constants and helpers for the serial-to-parallel receiver and its word queue.
package deser_fifo_pkg;

    localparam bit BIT_ORDER_LSB  = 1'b0;
    localparam bit BIT_ORDER_MSB  = 1'b1;
    localparam bit DEQ_MODE_EDGE  = 1'b0;
    localparam bit DEQ_MODE_LEVEL = 1'b1;

    function automatic int len_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/deser_fifo_if.sv
// Bit-input / word-output bus of deser_fifo; master drives bits and pops, slave returns words and status.
interface deser_fifo_if
    import deser_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int LEN_W = len_width(DEPTH);

    logic             data_in;
    logic             write_in;
    logic             status_out;
    logic             dequeue_in;
    logic             flush_in;
    logic [WIDTH-1:0] data_out;
    logic [LEN_W-1:0] len_out;
    logic             overflow_out;

    modport master (
        output data_in, write_in, dequeue_in, flush_in,
        input  status_out, data_out, len_out, overflow_out
    );

    modport slave (
        input  data_in, write_in, dequeue_in, flush_in,
        output status_out, data_out, len_out, overflow_out
    );

endinterface

// File: rtl/deser_fifo_word_fifo.sv
// First-word-fall-through word queue with flush; occupancy is a separate 0..DEPTH counter.
module word_fifo
    import deser_fifo_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 8,
    localparam int LEN_W = len_width(DEPTH),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] data_out,
    output logic [LEN_W-1:0] len_out,
    output logic [LEN_W-1:0] len_next,
    output logic             full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == LEN_W'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && (count_q != '0) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + LEN_W'(1);
                2'b01:   count_d = count_q - LEN_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; data_out is masked by the occupancy count so stale entries never show.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign data_out = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    assign len_out  = count_q;
    assign len_next = count_d;

endmodule

// File: rtl/deser_fifo.sv
// Serial bit assembler feeding a word FIFO, with dequeue edge/level mode, flush and sticky overflow.
module deser_fifo
    import deser_fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter bit MSB_FIRST = BIT_ORDER_MSB,
    parameter bit DEQ_LEVEL = DEQ_MODE_EDGE
) (
    input  logic         clock,
    input  logic         reset,
    deser_fifo_if.slave  bus
);

    localparam int LEN_W = len_width(DEPTH);
    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             overflow_q, overflow_d;
    logic             status_q, status_d;
    logic             dq_prev_q, dq_prev_d;

    logic [WIDTH-1:0] shifted;
    logic             accept;
    logic             pop_req;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic [LEN_W-1:0] len_next;

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        overflow_d = overflow_q;
        dq_prev_d  = bus.dequeue_in;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;

        if (MSB_FIRST == BIT_ORDER_LSB) shifted = {bus.data_in, shift_q[WIDTH-1:1]};
        else                            shifted = {shift_q[WIDTH-2:0], bus.data_in};

        accept  = bus.write_in && status_q;
        pop_req = (DEQ_LEVEL == DEQ_MODE_LEVEL) ? bus.dequeue_in
                                                : (bus.dequeue_in && !dq_prev_q);

        if (bus.flush_in) begin
            bit_cnt_d  = '0;
            shift_d    = '0;
            overflow_d = 1'b0;
        end else begin
            fifo_pop = pop_req;
            if (accept) begin
                if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                    fifo_push = !fifo_full;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    shift_d   = shifted;
                end
            end else if (bus.write_in) begin
                overflow_d = 1'b1;
            end
        end
    end

    // Ready is registered from next-cycle occupancy, so it is low in exactly the cycles the queue is full.
    assign status_d = (len_next < LEN_W'(DEPTH));

    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            overflow_q <= 1'b0;
            status_q   <= 1'b0;
            dq_prev_q  <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            overflow_q <= overflow_d;
            status_q   <= status_d;
            dq_prev_q  <= dq_prev_d;
        end
    end

    word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_word_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .flush    (bus.flush_in),
        .wdata    (shifted),
        .data_out (bus.data_out),
        .len_out  (bus.len_out),
        .len_next (len_next),
        .full     (fifo_full)
    );

    assign bus.status_out   = status_q;
    assign bus.overflow_out = overflow_q;

endmodule

// File: doc/deser_fifo.md
Name: deser_fifo

Overview:
Parametrised serial-to-parallel receiver with an integrated word queue, replacing the fixed 8-bit deserializer/queue pair in top.
- Input side: one bit is accepted per write_in strobe. Every WIDTH bits form one word, which is pushed into a DEPTH-entry FIFO.
- Output side: first-word-fall-through, popped by dequeue_in.
- Additions over the previous generation: configurable bit order, dequeue mode (edge or level), a flush input, and a sticky overflow flag.

Parameters:
- WIDTH, 8, bits per assembled word (2..32).
- DEPTH, 8, FIFO entries (power of 2, 2..64).
- MSB_FIRST, 1, 1 = first serial bit lands in data[WIDTH-1]; 0 = first bit lands in data[0].
- DEQ_LEVEL, 0, 0 = one pop per rising edge of dequeue_in; 1 = one pop per clock while dequeue_in is high.

Ports:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- data_in  in  1  serial data bit, sampled when write_in=1.
- write_in  in  1  bit strobe, level; every clock with write_in=1 and status_out=1 consumes one bit.
- status_out  out  1  ready to accept bits (FIFO not full).
- dequeue_in  in  1  pop request (see DEQ_LEVEL).
- flush_in  in  1  synchronous clear of FIFO, partial word and overflow flag.
- data_out  out  WIDTH  head-of-FIFO word; 0 when empty.
- len_out  out  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow_out  out  1  sticky; set by any write_in=1 while status_out=0.

Behaviour:
- Reset (synchronous): all outputs are 0; bit counter is 0; shift register is 0; dequeue edge register is 0.
  - status_out rises on the first clock after reset deasserts.
- Bit capture: a bit is accepted on the clock edge where write_in=1 and status_out=1.
  - The bit counter advances 0..WIDTH-1.
  - The shift register inserts data_in at the position given by MSB_FIRST.
  - write_in held high for N clocks consumes N bits. The strobe is level, not edge.
- Word completion: when the WIDTH-th bit is accepted, the assembled word is written to the FIFO tail on that same edge.
  - The bit counter returns to 0 and the shift register clears.
  - len_out and data_out (if the FIFO was empty) reflect the new word on the next cycle. Latency from last bit to visibility is 1 clock.
- status_out: a register equal to (len_next < DEPTH).
  - It is low whenever the FIFO is full, so a word can never complete into a full FIFO.
  - A partially assembled word is held while status_out=0 and resumes when space frees.
- Overflow: write_in=1 while status_out=0 drops the bit, leaves the counter unchanged, and sets overflow_out.
  - overflow_out clears only on reset or flush_in.
- Dequeue, DEQ_LEVEL=0: a pop occurs on the clock where dequeue_in=1 and the registered previous dequeue_in=0, i.e. exactly one pop per assertion regardless of how long it is held.
- Dequeue, DEQ_LEVEL=1: one pop per clock while dequeue_in=1.
- Pop when empty: ignored. No state change, no flag.
- Simultaneous push and pop: len_out is unchanged, the head advances and the tail advances.
  - If the FIFO was empty, the pop is ignored and the push proceeds.
- Pointer arithmetic: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy is tracked in a separate counter, 0..DEPTH.
- flush_in: takes priority over write_in and dequeue_in in the same cycle.
  - Clears len_out, the pointers, the bit counter, the shift register and overflow_out.
  - data_out is 0 next cycle; status_out is 1 next cycle.
- Priority: reset > flush_in > push/pop.

Decomposition:
- Package deser_fifo_pkg:
  - function len_width(depth) returning $clog2(depth+1).
  - Localparams for bit-order and dequeue-mode encodings.
- Sub-module word_fifo (WIDTH, DEPTH):
  - Synchronous FWFT FIFO with push, pop, flush, data_out, len_out and full.
  - The deser_fifo top keeps the bit assembler, dequeue edge detect, status and overflow logic.

Test Plan:
- Defaults, reset held 3 clocks, then send bits 1,0,0,0,0,0,0,0 at 1 bit per 2 clocks -> len_out=1, data_out=8'h80 one clock after the 8th bit; status_out=1 throughout.
- MSB_FIRST=0, same bit stream -> data_out=8'h01.
- Push 8 words 8'h80..8'h87 -> after the 8th word len_out=8 and status_out=0. A further write_in pulse -> overflow_out=1, len_out stays 8.
  - One dequeue -> len_out=7, data_out=8'h81, status_out=1.
- DEQ_LEVEL=0, 4 words queued, dequeue_in held 200 clocks -> exactly one pop, len_out 4->3. Repeat with DEQ_LEVEL=1 -> FIFO drains in 4 clocks, len_out=0, data_out=0.
- FIFO with len_out=3, final bit of a word coincides with a dequeue edge -> len_out stays 3 and the head advances. Then flush_in during a half-received word -> len_out=0, overflow_out=0, and the next 8 bits form a clean word.
- Reset asserted mid-word and at len_out=5 -> next clock all outputs are 0; the first word after release is assembled from bit 0 without stale bits.
